uart_echo_ctrl: RTL and testbench

UART_ECHO_CTRL -- requirements
Module: uart_echo_ctrl

---
 rtl/uart_echo_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_uart_echo_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_ctrl.sv
// UART echo controller: buffers received bytes in a FIFO and replays them to a
// transmitter, optionally bit-inverted, while tracking receiver error statistics.
module uart_echo_ctrl #(
   parameter int PACK_SIZE   = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int HOLD_CYCLES = 100000000,
   parameter int CNT_W       = 16,
   parameter bit DROP_BAD    = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    mode,
   input  logic                          clr_stats,
   input  logic                          rx_byte_valid,
   input  logic [PACK_SIZE-1:0]          rx_byte_data,
   input  logic                          par_error,
   input  logic                          stop_error,
   input  logic                          tx_active,
   output logic                          tx_byte_valid,
   output logic [PACK_SIZE-1:0]          tx_byte_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic                          par_err_led,
   output logic                          stop_err_led,
   output logic [CNT_W-1:0]              par_err_cnt,
   output logic [CNT_W-1:0]              stop_err_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_START,
      WAIT_DONE
   } tx_state_e;

   tx_state_e state_q, state_d;

   logic [PACK_SIZE-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [PACK_SIZE-1:0] tx_data_q, tx_data_d;
   logic                 ovf_q, ovf_d;
   logic [HW-1:0]        par_hold_q, par_hold_d;
   logic [HW-1:0]        stop_hold_q, stop_hold_d;
   logic [CNT_W-1:0]     par_cnt_q, par_cnt_d;
   logic [CNT_W-1:0]     stop_cnt_q, stop_cnt_d;

   logic fifo_full;
   logic fifo_empty;
   logic push_req;
   logic push;
   logic pop;
   logic ovf_event;

   // Fullness comes from the registered count only, so a pop in the same
   // cycle never makes room for an incoming byte.
   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);

   always_comb begin
      push_req  = 1'b0;
      push      = 1'b0;
      ovf_event = 1'b0;
      if (rx_byte_valid && (mode != 2'b11) && !(DROP_BAD && (par_error || stop_error))) begin
         push_req = 1'b1;
      end
      if (push_req) begin
         if (fifo_full) begin
            ovf_event = 1'b1;
         end else begin
            push = 1'b1;
         end
      end
   end

   // Launch decisions (and the mode they use) are only taken in IDLE, so a
   // transfer already under way always finishes with its original data.
   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && !tx_active && !mode[1]) begin
               pop       = 1'b1;
               tx_data_d = mode[0] ? ~mem[rd_ptr_q] : mem[rd_ptr_q];
               state_d   = LAUNCH;
            end
         end
         LAUNCH: begin
            state_d = WAIT_START;
         end
         WAIT_START: begin
            if (tx_active) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!tx_active) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Statistics: clr_stats wins over any event arriving in the same cycle,
   // while the LED hold timers keep running independently of it.
   always_comb begin
      ovf_d       = ovf_q;
      par_cnt_d   = par_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      par_hold_d  = par_hold_q;
      stop_hold_d = stop_hold_q;

      if (clr_stats) begin
         ovf_d      = 1'b0;
         par_cnt_d  = '0;
         stop_cnt_d = '0;
      end else begin
         if (ovf_event) begin
            ovf_d = 1'b1;
         end
         if (par_error && (par_cnt_q != '1)) begin
            par_cnt_d = par_cnt_q + CNT_W'(1);
         end
         if (stop_error && (stop_cnt_q != '1)) begin
            stop_cnt_d = stop_cnt_q + CNT_W'(1);
         end
      end

      if (par_error) begin
         par_hold_d = HW'(HOLD_CYCLES);
      end else if (par_hold_q != '0) begin
         par_hold_d = par_hold_q - HW'(1);
      end

      if (stop_error) begin
         stop_hold_d = HW'(HOLD_CYCLES);
      end else if (stop_hold_q != '0) begin
         stop_hold_d = stop_hold_q - HW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         tx_data_q   <= '0;
         ovf_q       <= 1'b0;
         par_cnt_q   <= '0;
         stop_cnt_q  <= '0;
         par_hold_q  <= '0;
         stop_hold_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         tx_data_q   <= tx_data_d;
         ovf_q       <= ovf_d;
         par_cnt_q   <= par_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         par_hold_q  <= par_hold_d;
         stop_hold_q <= stop_hold_d;
      end
   end

   // Storage needs no reset: entries are only ever read behind the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= rx_byte_data;
      end
   end

   assign tx_byte_valid = (state_q == LAUNCH);
   assign tx_byte_data  = tx_data_q;
   assign fifo_count    = count_q;
   assign overflow      = ovf_q;
   assign par_err_led   = (par_hold_q != '0);
   assign stop_err_led  = (stop_hold_q != '0);
   assign par_err_cnt   = par_cnt_q;
   assign stop_err_cnt  = stop_cnt_q;

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Directed self-checking bench for uart_echo_ctrl with a simple transmitter
// model that answers each launch with a few busy cycles.
module tb_uart_echo_ctrl;

   logic       clk;
   logic       rst;
   logic [1:0] mode;
   logic       clr_stats;
   logic       rx_byte_valid;
   logic [7:0] rx_byte_data;
   logic       par_error;
   logic       stop_error;
   logic       tx_active;
   logic       tx_byte_valid;
   logic [7:0] tx_byte_data;
   logic [4:0] fifo_count;
   logic       overflow;
   logic       par_err_led;
   logic       stop_err_led;
   logic [3:0] par_err_cnt;
   logic [3:0] stop_err_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int launch_cnt = 0;
   logic [7:0] sent_q [$];

   uart_echo_ctrl #(
      .PACK_SIZE  (8),
      .FIFO_DEPTH (16),
      .HOLD_CYCLES(10),
      .CNT_W      (4),
      .DROP_BAD   (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mode         (mode),
      .clr_stats    (clr_stats),
      .rx_byte_valid(rx_byte_valid),
      .rx_byte_data (rx_byte_data),
      .par_error    (par_error),
      .stop_error   (stop_error),
      .tx_active    (tx_active),
      .tx_byte_valid(tx_byte_valid),
      .tx_byte_data (tx_byte_data),
      .fifo_count   (fifo_count),
      .overflow     (overflow),
      .par_err_led  (par_err_led),
      .stop_err_led (stop_err_led),
      .par_err_cnt  (par_err_cnt),
      .stop_err_cnt (stop_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transmitter model: records each launch, stays busy three cycles and
   // checks the strobe is a single cycle and the data holds meanwhile.
   initial begin : tx_model
      logic [7:0] captured;
      tx_active = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_byte_valid === 1'b1) begin
            captured = tx_byte_data;
            sent_q.push_back(captured);
            launch_cnt++;
            tx_active = 1'b1;
            @(negedge clk);
            n_checks++;
            if (tx_byte_valid !== 1'b0) $display("[TB] FAIL launch_pulse_width got %b expected 0", tx_byte_valid);
            else n_pass++;
            repeat (2) @(negedge clk);
            if (rst === 1'b0) begin
               n_checks++;
               if (tx_byte_data !== captured) $display("[TB] FAIL tx_data_hold got %h expected %h", tx_byte_data, captured);
               else n_pass++;
            end
            tx_active = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("[TB] FAIL watchdog timeout got running expected finished");
      $fatal(1, "[TB] simulation did not finish");
   end

   task automatic send_byte(input logic [7:0] d, input logic pe, input logic se);
      rx_byte_valid = 1'b1;
      rx_byte_data  = d;
      par_error     = pe;
      stop_error    = se;
      @(negedge clk);
      rx_byte_valid = 1'b0;
      par_error     = 1'b0;
      stop_error    = 1'b0;
   endtask

   task automatic pulse_errors(input logic pe, input logic se, input logic clr);
      par_error  = pe;
      stop_error = se;
      clr_stats  = clr;
      @(negedge clk);
      par_error  = 1'b0;
      stop_error = 1'b0;
      clr_stats  = 1'b0;
   endtask

   task automatic wait_launches(input int target);
      int cyc = 0;
      while ((launch_cnt < target || tx_active) && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (launch_cnt < target) $display("[TB] FAIL drain_timeout got %0d launches expected %0d", launch_cnt, target);
      else n_pass++;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (tx_byte_valid !== 1'b0) $display("[TB] FAIL reset_tx_valid got %b expected 0", tx_byte_valid); else n_pass++;
      n_checks++;
      if (tx_byte_data !== 8'h00) $display("[TB] FAIL reset_tx_data got %h expected 00", tx_byte_data); else n_pass++;
      n_checks++;
      if (fifo_count !== 5'd0) $display("[TB] FAIL reset_fifo_count got %0d expected 0", fifo_count); else n_pass++;
      n_checks++;
      if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow got %b expected 0", overflow); else n_pass++;
      n_checks++;
      if ({par_err_led, stop_err_led} !== 2'b00) $display("[TB] FAIL reset_leds got %b expected 00", {par_err_led, stop_err_led}); else n_pass++;
      n_checks++;
      if ({par_err_cnt, stop_err_cnt} !== 8'h00) $display("[TB] FAIL reset_counters got %h expected 00", {par_err_cnt, stop_err_cnt}); else n_pass++;
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_echo();
      int base = launch_cnt;
      sent_q.delete();
      mode = 2'b00;
      send_byte(8'h41, 1'b0, 1'b0);
      n_checks++;
      if (fifo_count !== 5'd1) $display("[TB] FAIL echo_count_after_push got %0d expected 1", fifo_count); else n_pass++;
      wait_launches(base + 1);
      n_checks++;
      if (launch_cnt !== base + 1) $display("[TB] FAIL echo_launches got %0d expected %0d", launch_cnt, base + 1); else n_pass++;
      n_checks++;
      if (sent_q[0] !== 8'h41) $display("[TB] FAIL echo_data got %h expected 41", sent_q[0]); else n_pass++;
      n_checks++;
      if (fifo_count !== 5'd0) $display("[TB] FAIL echo_count_final got %0d expected 0", fifo_count); else n_pass++;
   endtask

   task automatic test_invert();
      int base = launch_cnt;
      sent_q.delete();
      mode = 2'b01;
      send_byte(8'h0F, 1'b0, 1'b0);
      wait_launches(base + 1);
      n_checks++;
      if (sent_q[0] !== 8'hF0) $display("[TB] FAIL invert_data got %h expected F0", sent_q[0]); else n_pass++;
   endtask

   task automatic test_pause_overflow();
      int base = launch_cnt;
      logic [7:0] exp_b;
      sent_q.delete();
      mode = 2'b10;
      for (int i = 0; i < 20; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b0);
      n_checks++;
      if (fifo_count !== 5'd16) $display("[TB] FAIL pause_count got %0d expected 16", fifo_count); else n_pass++;
      n_checks++;
      if (overflow !== 1'b1) $display("[TB] FAIL pause_overflow got %b expected 1", overflow); else n_pass++;
      n_checks++;
      if (launch_cnt !== base) $display("[TB] FAIL pause_no_launch got %0d expected %0d", launch_cnt, base); else n_pass++;
      pulse_errors(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (overflow !== 1'b0) $display("[TB] FAIL clr_overflow got %b expected 0", overflow); else n_pass++;
      // Leaving pause pops on the same edge the next byte arrives while full.
      mode = 2'b00;
      send_byte(8'hAA, 1'b0, 1'b0);
      n_checks++;
      if (fifo_count !== 5'd15) $display("[TB] FAIL full_pop_push_count got %0d expected 15", fifo_count); else n_pass++;
      n_checks++;
      if (overflow !== 1'b1) $display("[TB] FAIL full_pop_push_overflow got %b expected 1", overflow); else n_pass++;
      wait_launches(base + 16);
      n_checks++;
      if (sent_q.size() !== 16) $display("[TB] FAIL pause_sent_size got %0d expected 16", sent_q.size()); else n_pass++;
      for (int i = 0; i < 16; i++) begin
         exp_b = 8'h10 + 8'(i);
         n_checks++;
         if (sent_q[i] !== exp_b) $display("[TB] FAIL pause_order[%0d] got %h expected %h", i, sent_q[i], exp_b); else n_pass++;
      end
      pulse_errors(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_push_pop();
      int base = launch_cnt;
      sent_q.delete();
      mode = 2'b10;
      send_byte(8'h21, 1'b0, 1'b0);
      send_byte(8'h22, 1'b0, 1'b0);
      mode = 2'b00;
      send_byte(8'h23, 1'b0, 1'b0);
      n_checks++;
      if (fifo_count !== 5'd2) $display("[TB] FAIL push_pop_count got %0d expected 2", fifo_count); else n_pass++;
      wait_launches(base + 3);
      n_checks++;
      if ({sent_q[0], sent_q[1], sent_q[2]} !== 24'h212223) $display("[TB] FAIL push_pop_order got %h expected 212223", {sent_q[0], sent_q[1], sent_q[2]}); else n_pass++;
      n_checks++;
      if (fifo_count !== 5'd0) $display("[TB] FAIL push_pop_final got %0d expected 0", fifo_count); else n_pass++;
   endtask

   task automatic test_drop_bad();
      int lit = 0;
      int g = 0;
      int base;
      pulse_errors(1'b0, 1'b0, 1'b1);
      mode = 2'b10;
      send_byte(8'h55, 1'b1, 1'b0);
      n_checks++;
      if (fifo_count !== 5'd0) $display("[TB] FAIL drop_par_count got %0d expected 0", fifo_count); else n_pass++;
      n_checks++;
      if (par_err_cnt !== 4'd1) $display("[TB] FAIL drop_par_cnt got %0d expected 1", par_err_cnt); else n_pass++;
      n_checks++;
      if (stop_err_led !== 1'b0) $display("[TB] FAIL drop_stop_led_idle got %b expected 0", stop_err_led); else n_pass++;
      while (par_err_led === 1'b1 && g < 50) begin
         lit++;
         @(negedge clk);
         g++;
      end
      n_checks++;
      if (lit !== 10) $display("[TB] FAIL par_led_hold got %0d cycles expected 10", lit); else n_pass++;
      send_byte(8'h66, 1'b0, 1'b1);
      n_checks++;
      if ({fifo_count, stop_err_cnt} !== {5'd0, 4'd1}) $display("[TB] FAIL drop_stop got count %0d cnt %0d expected 0 1", fifo_count, stop_err_cnt); else n_pass++;
      mode = 2'b11;
      send_byte(8'h77, 1'b0, 1'b0);
      n_checks++;
      if (fifo_count !== 5'd0) $display("[TB] FAIL discard_mode_count got %0d expected 0", fifo_count); else n_pass++;
      mode = 2'b10;
      send_byte(8'h78, 1'b0, 1'b0);
      n_checks++;
      if (fifo_count !== 5'd1) $display("[TB] FAIL good_byte_count got %0d expected 1", fifo_count); else n_pass++;
      base = launch_cnt;
      sent_q.delete();
      mode = 2'b00;
      wait_launches(base + 1);
      n_checks++;
      if (sent_q[0] !== 8'h78) $display("[TB] FAIL good_byte_data got %h expected 78", sent_q[0]); else n_pass++;
   endtask

   task automatic test_err_led_retrigger();
      int lit = 0;
      int g = 0;
      pulse_errors(1'b1, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      pulse_errors(1'b1, 1'b0, 1'b0);
      while (par_err_led === 1'b1 && g < 50) begin
         lit++;
         @(negedge clk);
         g++;
      end
      n_checks++;
      if (lit !== 10) $display("[TB] FAIL par_led_retrigger got %0d cycles expected 10", lit); else n_pass++;
      n_checks++;
      if (par_err_cnt !== 4'd3) $display("[TB] FAIL par_cnt_after_retrigger got %0d expected 3", par_err_cnt); else n_pass++;
   endtask

   task automatic test_saturate();
      pulse_errors(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) pulse_errors(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (stop_err_cnt !== 4'hF) $display("[TB] FAIL stop_cnt_full got %h expected F", stop_err_cnt); else n_pass++;
      pulse_errors(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (stop_err_cnt !== 4'hF) $display("[TB] FAIL stop_cnt_saturate got %h expected F", stop_err_cnt); else n_pass++;
      pulse_errors(1'b0, 1'b1, 1'b1);
      n_checks++;
      if (stop_err_cnt !== 4'h0) $display("[TB] FAIL clr_beats_stop got %h expected 0", stop_err_cnt); else n_pass++;
      n_checks++;
      if ({stop_err_led, par_err_cnt} !== {1'b1, 4'h0}) $display("[TB] FAIL clr_led_and_par got %b expected 10000", {stop_err_led, par_err_cnt}); else n_pass++;
   endtask

   task automatic test_reset_mid_transfer();
      int g = 0;
      int base;
      sent_q.delete();
      mode = 2'b10;
      for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i), 1'b0, 1'b0);
      mode = 2'b00;
      while (tx_byte_valid !== 1'b1 && g < 20) begin
         @(negedge clk);
         g++;
      end
      n_checks++;
      if (tx_byte_valid !== 1'b1) $display("[TB] FAIL mid_launch_seen got %b expected 1", tx_byte_valid); else n_pass++;
      n_checks++;
      if (fifo_count !== 5'd3) $display("[TB] FAIL mid_buffered got %0d expected 3", fifo_count); else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if ({tx_byte_valid, tx_byte_data} !== 9'h000) $display("[TB] FAIL mid_reset_tx got %h expected 000", {tx_byte_valid, tx_byte_data}); else n_pass++;
      n_checks++;
      if ({fifo_count, overflow} !== 6'd0) $display("[TB] FAIL mid_reset_fifo got %h expected 00", {fifo_count, overflow}); else n_pass++;
      n_checks++;
      if ({par_err_led, stop_err_led, par_err_cnt, stop_err_cnt} !== 10'd0) $display("[TB] FAIL mid_reset_stats got %h expected 000", {par_err_led, stop_err_led, par_err_cnt, stop_err_cnt}); else n_pass++;
      base = launch_cnt;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      n_checks++;
      if (launch_cnt !== base) $display("[TB] FAIL mid_no_relaunch got %0d expected %0d", launch_cnt, base); else n_pass++;
      sent_q.delete();
      send_byte(8'h99, 1'b0, 1'b0);
      wait_launches(base + 1);
      n_checks++;
      if (sent_q[0] !== 8'h99) $display("[TB] FAIL post_reset_data got %h expected 99", sent_q[0]); else n_pass++;
   endtask

   initial begin
      rst           = 1'b1;
      mode          = 2'b00;
      clr_stats     = 1'b0;
      rx_byte_valid = 1'b0;
      rx_byte_data  = 8'h00;
      par_error     = 1'b0;
      stop_error    = 1'b0;
      test_reset();
      test_echo();
      test_invert();
      test_pause_overflow();
      test_push_pop();
      test_drop_bad();
      test_err_led_retrigger();
      test_saturate();
      test_reset_mid_transfer();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
